// File: rtl/id_queue_reader_if.sv
// -----------------------------------------------------------------------------
// id_queue_reader_if
// Bundles the three streams around id_queue_reader:
//   req_*  : lookup request stream (valid/ready) into the reader
//   oup_*  : id_queue output-port request/grant and read data
//   rsp_*  : lookup response stream (valid/ready) out of the reader
// Signal suffixes (_i/_o) are from the reader's point of view.
// slave  modport : the reader itself
// master modport : whatever drives requests, models the queue and sinks responses
// -----------------------------------------------------------------------------
interface id_queue_reader_if #(
    parameter int unsigned ID_WIDTH    = 10,
    parameter type         data_t      = logic [3:0],
    parameter int unsigned MAX_RETRIES = 8
);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

    logic [ID_WIDTH-1:0] req_id_i;
    logic                req_pop_i;
    logic                req_valid_i;
    logic                req_ready_o;

    logic [ID_WIDTH-1:0] oup_id_o;
    logic                oup_pop_o;
    logic                oup_req_o;
    logic                oup_gnt_i;
    logic                oup_data_valid_i;
    data_t               oup_data_i;

    data_t               rsp_data_o;
    logic [ID_WIDTH-1:0] rsp_id_o;
    logic                rsp_found_o;
    logic [RW-1:0]       rsp_retries_o;
    logic                rsp_valid_o;
    logic                rsp_ready_i;

    modport slave (
        input  req_id_i, req_pop_i, req_valid_i,
        output req_ready_o,
        output oup_id_o, oup_pop_o, oup_req_o,
        input  oup_gnt_i, oup_data_valid_i, oup_data_i,
        output rsp_data_o, rsp_id_o, rsp_found_o, rsp_retries_o, rsp_valid_o,
        input  rsp_ready_i
    );

    modport master (
        output req_id_i, req_pop_i, req_valid_i,
        input  req_ready_o,
        input  oup_id_o, oup_pop_o, oup_req_o,
        output oup_gnt_i, oup_data_valid_i, oup_data_i,
        input  rsp_data_o, rsp_id_o, rsp_found_o, rsp_retries_o, rsp_valid_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/id_queue_reader.sv
// -----------------------------------------------------------------------------
// id_queue_reader
// Accepts one ID lookup at a time, issues it to an id_queue output port, and
// returns the read data (or a miss) on a response stream. With RETRY set, a
// miss is re-issued after BACKOFF_CYCLES idle cycles, up to MAX_RETRIES times.
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_ni  : asynchronous active-low reset
//   clr_i   : synchronous clear, same effect as reset
//   bus     : slave side of id_queue_reader_if (req_*, oup_*, rsp_* streams)
// -----------------------------------------------------------------------------
module id_queue_reader #(
    parameter int unsigned ID_WIDTH       = 10,
    parameter type         data_t         = logic [3:0],
    parameter bit          RETRY          = 1'b0,
    parameter int unsigned BACKOFF_CYCLES = 4,
    parameter int unsigned MAX_RETRIES    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    id_queue_reader_if.slave      bus
);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
    localparam int unsigned BW = $clog2(BACKOFF_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BACKOFF, RESP} state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic                pop_q, pop_d;
    logic [RW-1:0]       cnt_q, cnt_d;     // re-issues consumed so far
    logic [BW-1:0]       bo_q, bo_d;       // remaining backoff cycles
    data_t               data_q, data_d;
    logic                found_q, found_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            pop_q   <= 1'b0;
            cnt_q   <= '0;
            bo_q    <= '0;
            data_q  <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pop_q   <= pop_d;
            cnt_q   <= cnt_d;
            bo_q    <= bo_d;
            data_q  <= data_d;
            found_q <= found_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        pop_d   = pop_q;
        cnt_d   = cnt_q;
        bo_d    = bo_q;
        data_d  = data_q;
        found_d = found_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    id_d    = bus.req_id_i;
                    pop_d   = bus.req_pop_i;
                    cnt_d   = '0;
                    bo_d    = '0;
                    data_d  = '0;
                    found_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.oup_gnt_i) begin
                    if (bus.oup_data_valid_i) begin
                        data_d  = bus.oup_data_i;
                        found_d = 1'b1;
                        state_d = RESP;
                    end else if (RETRY && (cnt_q < RW'(MAX_RETRIES))) begin
                        cnt_d   = cnt_q + 1'b1;
                        bo_d    = BW'(BACKOFF_CYCLES);
                        state_d = BACKOFF;
                    end else begin
                        data_d  = '0;
                        found_d = 1'b0;
                        state_d = RESP;
                    end
                end
            end
            BACKOFF: begin
                // Entered with BACKOFF_CYCLES, leaves on the cycle it reads 1,
                // so the request line stays low for exactly BACKOFF_CYCLES.
                bo_d = bo_q - 1'b1;
                if (bo_q == BW'(1)) state_d = ISSUE;
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clr_i) begin
            state_d = IDLE;
            id_d    = '0;
            pop_d   = 1'b0;
            cnt_d   = '0;
            bo_d    = '0;
            data_d  = '0;
            found_d = 1'b0;
        end
    end

    // Ready is masked during reset/clear so no handshake completes while the
    // state is being forced back to IDLE.
    assign bus.req_ready_o   = (state_q == IDLE) && rst_ni && !clr_i;

    assign bus.oup_req_o     = (state_q == ISSUE);
    assign bus.oup_id_o      = (state_q == ISSUE) ? id_q : '0;
    assign bus.oup_pop_o     = (state_q == ISSUE) && pop_q;

    assign bus.rsp_valid_o   = (state_q == RESP);
    assign bus.rsp_data_o    = data_q;
    assign bus.rsp_id_o      = id_q;
    assign bus.rsp_found_o   = found_q;
    assign bus.rsp_retries_o = cnt_q;
endmodule

// File: doc/id_queue_reader.md
ID_QUEUE_READER -- requirements
Module: id_queue_reader

Interface
REQ-001 Parameter ID_WIDTH, default 10, width of request and queue IDs.
REQ-002 Parameter data_t, default logic[3:0], type of queue data words.
REQ-003 Parameter RETRY, default 1'b0, re-issue lookup after a miss when set.
REQ-004 Parameter BACKOFF_CYCLES, default 4 (>=1), idle cycles between miss and re-issue.
REQ-005 Parameter MAX_RETRIES, default 8 (>=1), re-issues allowed per request; RW = $clog2(MAX_RETRIES+1).
REQ-006 clk_i  input  1  clock; one clock, all state on rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 clr_i  input  1  synchronous clear, same effect as reset.
REQ-009 req_id_i  input  ID_WIDTH  ID to look up.
REQ-010 req_pop_i  input  1  remove entry on successful lookup.
REQ-011 req_valid_i / req_ready_o  input/output  1  request stream handshake.
REQ-012 oup_id_o, oup_pop_o, oup_req_o  output  ID_WIDTH,1,1  id_queue output-port request.
REQ-013 oup_gnt_i, oup_data_valid_i  input  1,1  id_queue grant and hit flag.
REQ-014 oup_data_i  input  $bits(data_t)  id_queue read data.
REQ-015 rsp_data_o, rsp_id_o  output  $bits(data_t), ID_WIDTH  response payload and echoed ID.
REQ-016 rsp_found_o, rsp_retries_o  output  1, RW  hit flag; re-issues consumed.
REQ-017 rsp_valid_o / rsp_ready_i  output/input  1  response stream handshake.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, BACKOFF, RESP.
REQ-019 IDLE: req_ready_o=1; on req_valid_i SHALL latch req_id_i, req_pop_i, clear retry count, go ISSUE.
REQ-020 req_ready_o SHALL be 0 in every state except IDLE; no combinational path req_valid_i->oup_req_o.
REQ-021 ISSUE: oup_req_o=1, oup_id_o/oup_pop_o from latched values, held stable until oup_gnt_i.
REQ-022 oup_req_o SHALL be 0 outside ISSUE; oup_id_o/oup_pop_o SHALL be 0 outside ISSUE.
REQ-023 Grant with oup_data_valid_i=1: capture oup_data_i, found=1, go RESP.
REQ-024 Grant with oup_data_valid_i=0 and (RETRY=0 or count==MAX_RETRIES): data=0, found=0, go RESP.
REQ-025 Grant with miss, RETRY=1, count<MAX_RETRIES: increment count, load counter BACKOFF_CYCLES, go BACKOFF.
REQ-026 BACKOFF: counter decrements each cycle; at 1 -> ISSUE, so exactly BACKOFF_CYCLES cycles with oup_req_o=0.
REQ-027 RESP: rsp_valid_o=1, payload stable; on rsp_ready_i -> IDLE.
REQ-028 Latency: request accepted cycle N; ISSUE N+1; if granted same cycle, rsp_valid_o at N+2.
REQ-029 Minimum request spacing 3 cycles (IDLE, ISSUE, RESP); no back-to-back acceptance while RESP pending.
REQ-030 rsp_retries_o SHALL equal re-issues performed (0..MAX_RETRIES); no wrap.
REQ-031 oup_pop_o on a miss is harmless; block SHALL NOT suppress it.
REQ-032 clr_i in any state SHALL return to IDLE next cycle, dropping in-flight request and response.

Reset
REQ-033 During reset: state IDLE, req_ready_o=0 while rst_ni=0 then 1 after release, oup_req_o=0, oup_id_o=0, oup_pop_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_found_o=0, rsp_retries_o=0, counters 0.
REQ-034 Reset asserted mid-ISSUE/BACKOFF/RESP SHALL abort immediately, no response emitted.

Verification
REQ-035 Queue holds ID 0x3 data 0xA; request id=0x3 pop=1, gnt same cycle -> rsp data 0xA, found=1, retries=0 at N+2; entry removed.
REQ-036 RETRY=0, empty ID 0x5 -> one oup_req_o pulse, rsp found=0, data=0, retries=0.
REQ-037 RETRY=1, BACKOFF=4, ID 0x7 filled after 2nd miss -> 3 issues, 4 idle cycles between, rsp found=1, retries=2.
REQ-038 RETRY=1, MAX_RETRIES=8, never filled -> 9 issues total, rsp found=0, retries=8.
REQ-039 oup_gnt_i withheld 5 cycles, rsp_ready_i withheld 3 cycles -> oup_id_o and rsp payload stable, req_ready_o=0 throughout.
REQ-040 rst_ni low during BACKOFF, clr_i high during RESP -> all outputs at reset values, next request processed normally.
